// File: rtl/jpeg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_ctrl_pkg
// Description : Shared state encoding and sizing helpers for the JPEG
//               block sequencer and its row stepper.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_DCT        = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_QUANT      = 3'd4,
    ST_HUFF_START = 3'd5,
    ST_HUFF_WAIT  = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  localparam int ROWS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  // Bits needed to hold a count of 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_row_stepper.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_row_stepper
// Description : Walks matrix rows 0..7, holding each for QUANT_LATENCY+1
//               cycles and strobing on the final cycle of every hold.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_row_stepper
  import jpeg_ctrl_pkg::*;
#(
  parameter int QUANT_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [ROW_W-1:0] matrix_row,
  output logic             row_strobe,
  output logic             last_row
);

  localparam int HW = cnt_width(QUANT_LATENCY + 1);
  localparam logic [HW-1:0]    c_hold_max = HW'(QUANT_LATENCY);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(ROWS - 1);

  logic             r_active, w_active_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             r_last, w_last_nxt;

  always_comb begin
    w_active_nxt = r_active;
    w_row_nxt    = r_row;
    w_hold_nxt   = r_hold;
    if (abort) begin
      w_active_nxt = 1'b0;
      w_row_nxt    = '0;
      w_hold_nxt   = '0;
    end else if (start) begin
      w_active_nxt = 1'b1;
      w_row_nxt    = '0;
      w_hold_nxt   = '0;
    end else if (r_active) begin
      if (r_hold == c_hold_max) begin
        w_hold_nxt = '0;
        if (r_row == c_row_last) begin
          w_active_nxt = 1'b0;
          w_row_nxt    = '0;
        end else begin
          w_row_nxt = r_row + ROW_W'(1);
        end
      end else begin
        w_hold_nxt = r_hold + HW'(1);
      end
    end
    // Strobe and last flags are precomputed so they leave as flops.
    w_strobe_nxt = w_active_nxt && (w_hold_nxt == c_hold_max);
    w_last_nxt   = w_strobe_nxt && (w_row_nxt == c_row_last);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active <= 1'b0;
      r_row    <= '0;
      r_hold   <= '0;
      r_strobe <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_row    <= w_row_nxt;
      r_hold   <= w_hold_nxt;
      r_strobe <= w_strobe_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign matrix_row = r_row;
  assign row_strobe = r_strobe;
  assign last_row   = r_last;

endmodule
`default_nettype wire

// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_block_sequencer
// Description : Per-block control FSM for the 8x8 JPEG encode pipeline:
//               load, DCT, capture, 8 quantize rows, Huffman start/wait.
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer
  import jpeg_ctrl_pkg::*;
#(
  parameter int DCT_LATENCY   = 8,
  parameter int QUANT_LATENCY = 1,
  parameter int HUFF_TIMEOUT  = 1023,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             is_luminance_in,
  input  logic             abort,
  input  logic             huff_end,
  output logic             input_enable,
  output logic             dct_enable,
  output logic             dct_end_enable,
  output logic [7:0]       matrix_row,
  output logic             zigzag_input_enable,
  output logic             Huffman_start,
  output logic             is_luminance,
  output logic             busy,
  output logic             block_done,
  output logic [CNT_W-1:0] blk_count,
  output logic             err_timeout
);

  localparam int TW = cnt_width((DCT_LATENCY > HUFF_TIMEOUT) ? DCT_LATENCY : HUFF_TIMEOUT);
  localparam logic [TW-1:0] c_dct_last  = TW'(DCT_LATENCY - 1);
  localparam logic [TW-1:0] c_huff_last = TW'(HUFF_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_tmr;
  logic             w_hs, w_timeout;
  logic             w_step_start, w_step_abort, w_last_row, w_row_strobe;
  logic [ROW_W-1:0] w_row;

  logic             r_blk_ready, r_input_enable, r_dct_enable, r_dct_end_enable;
  logic             r_huff_start, r_is_lum, r_busy, r_block_done, r_err;
  logic [CNT_W-1:0] r_blk_count;

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_hs        = blk_valid && r_blk_ready;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       if (w_hs) w_state_nxt = ST_LOAD;
        ST_LOAD:       w_state_nxt = ST_DCT;
        ST_DCT:        if (r_tmr == c_dct_last) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE:    w_state_nxt = ST_QUANT;
        ST_QUANT:      if (w_last_row) w_state_nxt = ST_HUFF_START;
        ST_HUFF_START: w_state_nxt = ST_HUFF_WAIT;
        ST_HUFF_WAIT: begin
          // huff_end beats a coincident timeout
          if (huff_end) begin
            w_state_nxt = ST_DONE;
          end else if (r_tmr == c_huff_last) begin
            w_state_nxt = ST_DONE;
            w_timeout   = 1'b1;
          end
        end
        ST_DONE:       w_state_nxt = ST_IDLE;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_step_start = (r_state == ST_CAPTURE);
  assign w_step_abort = abort && (r_state != ST_IDLE);

  jpeg_row_stepper #(
    .QUANT_LATENCY (QUANT_LATENCY)
  ) u_row_stepper (
    .clock      (clock),
    .reset      (reset),
    .start      (w_step_start),
    .abort      (w_step_abort),
    .matrix_row (w_row),
    .row_strobe (w_row_strobe),
    .last_row   (w_last_row)
  );

  // Outputs are decoded from the next state so they land as flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_tmr            <= '0;
      r_blk_ready      <= 1'b0;
      r_input_enable   <= 1'b0;
      r_dct_enable     <= 1'b0;
      r_dct_end_enable <= 1'b0;
      r_huff_start     <= 1'b0;
      r_is_lum         <= 1'b0;
      r_busy           <= 1'b0;
      r_block_done     <= 1'b0;
      r_err            <= 1'b0;
      r_blk_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt == r_state) && ((r_state == ST_DCT) || (r_state == ST_HUFF_WAIT)))
        r_tmr <= r_tmr + TW'(1);
      else
        r_tmr <= '0;
      r_blk_ready      <= (w_state_nxt == ST_IDLE);
      r_input_enable   <= (w_state_nxt == ST_LOAD);
      r_dct_enable     <= (w_state_nxt == ST_DCT);
      r_dct_end_enable <= (w_state_nxt == ST_CAPTURE);
      r_huff_start     <= (w_state_nxt == ST_HUFF_START);
      r_busy           <= (w_state_nxt != ST_IDLE);
      r_block_done     <= (w_state_nxt == ST_DONE);
      if (w_hs && (r_state == ST_IDLE))
        r_is_lum <= is_luminance_in;
      if (w_timeout)
        r_err <= 1'b1;
      if (w_state_nxt == ST_DONE)
        r_blk_count <= r_blk_count + CNT_W'(1);
    end
  end

  assign blk_ready           = r_blk_ready;
  assign input_enable        = r_input_enable;
  assign dct_enable          = r_dct_enable;
  assign dct_end_enable      = r_dct_end_enable;
  assign matrix_row          = {{(8 - ROW_W){1'b0}}, w_row};
  assign zigzag_input_enable = w_row_strobe;
  assign Huffman_start       = r_huff_start;
  assign is_luminance        = r_is_lum;
  assign busy                = r_busy;
  assign block_done          = r_block_done;
  assign blk_count           = r_blk_count;
  assign err_timeout         = r_err;

endmodule
`default_nettype wire
